// File: rtl/sha256_pkg.sv
// Shared SHA-256 types: the per-job context handed to the datapath, the
// initial hash value, and the scheduler state encoding.
package sha256_pkg;

  typedef struct packed {
    logic [63:0]      length;
    logic [7:0][31:0] state;
    logic [31:0]      curlen;
    logic [511:0]     buffer;
  } ShaContext;

  // state[0] holds the first IV word
  localparam logic [7:0][31:0] H = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} SchedState;

endpackage

// File: rtl/sha_hash_match.sv
// Registered masked compare of each returned digest against the batch target.
// The job index and digest are held until the next match.
module sha_hash_match (
  input  logic         clk_axi,
  input  logic         rst,
  input  logic         fire,
  input  logic [31:0]  job,
  input  logic [255:0] hash,
  input  logic [255:0] target,
  input  logic [255:0] target_mask,
  output logic         match_vld,
  output logic [31:0]  match_job,
  output logic [255:0] match_hash
);

  logic hit;

  assign hit = fire && (((hash ^ target) & target_mask) == '0);

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      match_vld  <= 1'b0;
      match_job  <= '0;
      match_hash <= '0;
    end else begin
      match_vld <= hit;
      if (hit) begin
        match_job  <= job;
        match_hash <= hash;
      end
    end
  end

endmodule

// File: rtl/sha_job_scheduler.sv
// Issues a batch of SHA-256 contexts with stepped lengths to the datapath,
// bounds the in-flight count, and collects/matches the returned digests in order.
module sha_job_scheduler
  import sha256_pkg::*;
#(
  parameter int STRIDE          = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk_axi,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [63:0]  base_length,
  input  logic [31:0]  job_count,
  input  logic [255:0] target,
  input  logic [255:0] target_mask,
  output logic         busy,
  output logic         done,
  input  logic         ctx_rdy,
  output logic         ctx_vld,
  output ShaContext    ctx,
  output logic         hash_rdy,
  input  logic         hash_vld,
  input  logic [255:0] hash,
  output logic         match_vld,
  output logic [31:0]  match_job,
  output logic [255:0] match_hash,
  output logic [31:0]  match_count
);

  localparam logic [8:0]  MAX_OUT = 9'(MAX_OUTSTANDING);
  localparam logic [63:0] STEP    = 64'(STRIDE);

  SchedState    state, state_d;
  logic [31:0]  issued, issued_d, returned, returned_d, jobs_q;
  logic [8:0]   outs, outs_d;
  logic [63:0]  len_q;
  logic [255:0] target_q, mask_q;
  logic         accept, issue_fire, ret_fire;

  assign accept     = start && (state == IDLE);
  assign issue_fire = ctx_vld && ctx_rdy;
  assign ret_fire   = hash_vld && hash_rdy;

  assign ctx = {len_q, H, 32'd0, 512'd0};

  // Transitions look at next-cycle counts so the registered ctx_vld/hash_rdy
  // never overshoot the last job or linger after the final return.
  always_comb begin
    issued_d   = issued + 32'(issue_fire);
    returned_d = returned + 32'(ret_fire);
    outs_d     = outs + 9'(issue_fire) - 9'(ret_fire);
    if (accept) begin
      issued_d   = '0;
      returned_d = '0;
      outs_d     = '0;
    end
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = (job_count == '0) ? DONE : ISSUE;
      ISSUE:   if (abort || issued_d == jobs_q) state_d = DRAIN;
      DRAIN:   if (outs_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      issued      <= '0;
      returned    <= '0;
      outs        <= '0;
      jobs_q      <= '0;
      len_q       <= '0;
      target_q    <= '0;
      mask_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ctx_vld     <= 1'b0;
      hash_rdy    <= 1'b0;
      match_count <= '0;
    end else begin
      state    <= state_d;
      issued   <= issued_d;
      returned <= returned_d;
      outs     <= outs_d;
      busy     <= (state_d != IDLE);
      done     <= (state == DONE);
      ctx_vld  <= (state_d == ISSUE) && (outs_d < MAX_OUT);
      hash_rdy <= (state_d == ISSUE) || (state_d == DRAIN);
      if (accept) begin
        jobs_q   <= job_count;
        len_q    <= base_length;
        target_q <= target;
        mask_q   <= target_mask;
      end else if (issue_fire) begin
        len_q <= len_q + STEP;
      end
      if (accept) match_count <= '0;
      else if (match_vld && match_count != '1) match_count <= match_count + 32'd1;
    end
  end

  sha_hash_match u_match (
    .clk_axi     (clk_axi),
    .rst         (rst),
    .fire        (ret_fire),
    .job         (returned),
    .hash        (hash),
    .target      (target_q),
    .target_mask (mask_q),
    .match_vld   (match_vld),
    .match_job   (match_job),
    .match_hash  (match_hash)
  );

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Directed bench for sha_job_scheduler: issue stepping, throttling, matching,
// empty batch, abort drain and asynchronous reset.
module tb_sha_job_scheduler;
  import sha256_pkg::*;

  localparam logic [255:0] H_EXP =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

  logic         clk_axi = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic         ctx_rdy = 1'b0, hash_vld = 1'b0;
  logic [63:0]  base_length = '0;
  logic [31:0]  job_count = '0;
  logic [255:0] target = '0, target_mask = '0, hash = '0;
  logic         busy, done, ctx_vld, hash_rdy, match_vld;
  ShaContext    ctx;
  logic [31:0]  match_job, match_count;
  logic [255:0] match_hash;

  int n_chk = 0, n_pass = 0;

  always #5 clk_axi = ~clk_axi;

  sha_job_scheduler #(.STRIDE(8), .MAX_OUTSTANDING(4)) dut (
    .clk_axi(clk_axi), .rst(rst), .start(start), .abort(abort),
    .base_length(base_length), .job_count(job_count), .target(target),
    .target_mask(target_mask), .busy(busy), .done(done),
    .ctx_rdy(ctx_rdy), .ctx_vld(ctx_vld), .ctx(ctx),
    .hash_rdy(hash_rdy), .hash_vld(hash_vld), .hash(hash),
    .match_vld(match_vld), .match_job(match_job), .match_hash(match_hash),
    .match_count(match_count)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_axi);
    #1;
  endtask

  task automatic go(input logic [63:0] bl, input logic [31:0] jc,
                    input logic [255:0] t, input logic [255:0] m);
    base_length = bl; job_count = jc; target = t; target_mask = m;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic ret(input string tag, input logic [255:0] h);
    chk(tag, 256'(hash_rdy), 256'd1);
    hash = h; hash_vld = 1'b1;
    tick;
    hash_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (!done && i < budget) begin
      tick;
      i++;
    end
    chk(tag, 256'(done), 256'd1);
  endtask

  initial begin
    int fires;
    logic seen;
    logic [255:0] h1;

    #12;
    chk("rst_busy", 256'(busy), 0);
    chk("rst_done", 256'(done), 0);
    chk("rst_ctx_vld", 256'(ctx_vld), 0);
    chk("rst_hash_rdy", 256'(hash_rdy), 0);
    chk("rst_len", 256'(ctx.length), 0);
    chk("rst_state", 256'(ctx.state), H_EXP);
    chk("rst_curlen", 256'(ctx.curlen), 0);
    chk("rst_buffer", 256'(|ctx.buffer), 0);
    chk("rst_match_vld", 256'(match_vld), 0);
    chk("rst_match_job", 256'(match_job), 0);
    chk("rst_match_hash", match_hash, 0);
    chk("rst_match_count", 256'(match_count), 0);
    rst = 1'b0;

    // three jobs, lengths step by 8, nothing matches
    ctx_rdy = 1'b1;
    go(64'd512, 32'd3, '1, '1);
    chk("t1_busy", 256'(busy), 1);
    chk("t1_ctx_vld", 256'(ctx_vld), 1);
    chk("t1_len0", 256'(ctx.length), 256'd512);
    tick;
    chk("t1_len1", 256'(ctx.length), 256'd520);
    tick;
    chk("t1_len2", 256'(ctx.length), 256'd528);
    tick;
    chk("t1_vld_off", 256'(ctx_vld), 0);
    for (int i = 0; i < 3; i++) ret("t1_hrdy", 256'(i + 16'h0a00));
    chk("t1_done_early", 256'(done), 0);
    tick;
    chk("t1_done", 256'(done), 1);
    chk("t1_busy_off", 256'(busy), 0);
    chk("t1_mcount", 256'(match_count), 0);
    tick;
    chk("t1_done_pulse", 256'(done), 0);

    // empty batch
    go(64'd64, 32'd0, '0, '0);
    chk("t4_ctx_vld", 256'(ctx_vld), 0);
    chk("t4_done_early", 256'(done), 0);
    tick;
    chk("t4_done", 256'(done), 1);
    chk("t4_ctx_vld2", 256'(ctx_vld), 0);

    // throttle at 4 outstanding, zero mask matches everything
    go(64'd1000, 32'd10, '0, '0);
    fires = 0;
    repeat (8) begin
      fires += int'(ctx_vld && ctx_rdy);
      tick;
    end
    chk("t2_fires4", 256'(fires), 256'd4);
    chk("t2_vld_full", 256'(ctx_vld), 0);
    chk("t2_len", 256'(ctx.length), 256'd1032);
    ret("t2_hrdy", 256'd100);
    chk("t2_mvld", 256'(match_vld), 1);
    chk("t2_mjob0", 256'(match_job), 0);
    fires = 0;
    repeat (6) begin
      fires += int'(ctx_vld && ctx_rdy);
      tick;
    end
    chk("t2_fires1", 256'(fires), 256'd1);
    chk("t2_len5", 256'(ctx.length), 256'd1040);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t2_abort_vld", 256'(ctx_vld), 0);
    for (int i = 1; i < 5; i++) ret("t2_hrdy", 256'(i + 100));
    wait_done("t2_done", 5);
    chk("t2_mcount", 256'(match_count), 256'd5);
    chk("t2_mjob4", 256'(match_job), 256'd4);
    chk("t2_mhash", match_hash, 256'd104);

    // masked compare on the top 16 bits
    h1 = {16'h0000, 240'habcdef};
    go(64'd0, 32'd3, {16'h0000, {240{1'b1}}}, {16'hffff, 240'd0});
    repeat (3) tick;
    ret("t3_hrdy", {16'h1234, 240'd1});
    chk("t3_nomatch0", 256'(match_vld), 0);
    ret("t3_hrdy", h1);
    chk("t3_mvld", 256'(match_vld), 1);
    chk("t3_mjob", 256'(match_job), 256'd1);
    chk("t3_mhash", match_hash, h1);
    ret("t3_hrdy", {16'h8000, 240'd0});
    chk("t3_nomatch2", 256'(match_vld), 0);
    chk("t3_mjob_hold", 256'(match_job), 256'd1);
    tick;
    chk("t3_done", 256'(done), 1);
    chk("t3_mcount", 256'(match_count), 256'd1);

    // abort with a pending context: withdrawn, only two to drain
    go(64'd0, 32'd5, '1, '1);
    tick;
    tick;
    ctx_rdy = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    ctx_rdy = 1'b1;
    chk("t5_vld_off", 256'(ctx_vld), 0);
    seen = 1'b0;
    repeat (3) begin
      seen |= ctx_vld;
      tick;
    end
    chk("t5_no_vld", 256'(seen), 0);
    ret("t5_hrdy", 256'd1);
    ret("t5_hrdy", 256'd2);
    chk("t5_done_early", 256'(done), 0);
    tick;
    chk("t5_done", 256'(done), 1);

    // asynchronous reset mid-batch, then restart
    go(64'd2048, 32'd5, '0, '0);
    chk("t6_len", 256'(ctx.length), 256'd2048);
    tick;
    ret("t6_hrdy", 256'hbeef);
    tick;
    chk("t6_mcount", 256'(match_count), 256'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_busy", 256'(busy), 0);
    chk("t6_ctx_vld", 256'(ctx_vld), 0);
    chk("t6_hash_rdy", 256'(hash_rdy), 0);
    chk("t6_len_rst", 256'(ctx.length), 0);
    chk("t6_mvld", 256'(match_vld), 0);
    chk("t6_mhash", match_hash, 0);
    chk("t6_mcount_rst", 256'(match_count), 0);
    #2 rst = 1'b0;
    go(64'd2048, 32'd5, '0, '0);
    chk("t6_restart_vld", 256'(ctx_vld), 1);
    chk("t6_restart_len", 256'(ctx.length), 256'd2048);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
